nor_flash_read_ctrl: RTL
========================

// Module: nor_flash_read_ctrl
// PURPOSE
//  Read-only controller for an x8 asynchronous parallel NOR flash. Sits directly upstream of the
//  flash boot-loader/debug copier: accepts byte-address read requests, drives the flash pins with
//  programmable wait timing, and buffers returned bytes in a show-ahead FIFO for the consumer.
// PARAMETERS
//  P_ADDR_N      23  flash byte-address width (oFLASH_ADDR, iRQ_ADDR)
//  P_DATA_N      8   data width (iFLASH_DQ, oRD_DATA)
//  P_FIFO_DEPTH  8   read-data FIFO entries
//  P_FIFO_PTR_N  3   log2(P_FIFO_DEPTH)
//  P_ACC_WAIT    7   cycles CE/OE held low before DQ sampled (>=1); covers tACC
//  P_RST_WAIT    32  cycles onFLASH_RESET held low after inRESET release (>=1)
//  P_PAGE_WAIT   3   intra-page wait cycles (page-mode option only, >=1)
// PORTS
//  iCLOCK        in   1         system clock
//  inRESET       in   1         async active-low reset
//  iRQ_REQ       in   1         read request valid
//  oRQ_BUSY      out  1         request not accepted this cycle
//  iRQ_ADDR      in   P_ADDR_N  byte address, sampled on acceptance
//  iRD_REQ       in   1         pop FIFO head
//  oRD_BUSY      out  1         FIFO empty (oRD_DATA invalid)
//  oRD_DATA      out  P_DATA_N  FIFO head (show-ahead)
//  oFLASH_ADDR   out  P_ADDR_N  flash address (registered)
//  iFLASH_DQ     in   P_DATA_N  flash data
//  onFLASH_CE/OE out  1 each    chip/output enable, active-low, registered
//  onFLASH_WE    out  1         tied 1 (never writes)
//  onFLASH_RESET out  1         flash reset, active-low, registered
//  onFLASH_WP    out  1         tied 0 (boot block protected)
//  onFLASH_BYTE  out  1         tied 0 (x8 byte mode)
//  inFLASH_RY    in   1         ready/busy#, async; 2-flop synchronised (ry_s)
// BEHAVIOUR
//  Reset values: oFLASH_ADDR=0, onFLASH_CE=1, onFLASH_OE=1, onFLASH_RESET=0, FIFO empty
//   (oRD_BUSY=1, oRD_DATA=0), oRQ_BUSY=1, state=INIT, wait counter=P_RST_WAIT.
//  FSM: INIT -> IDLE -> ACCESS -> LATCH -> RECOVER -> IDLE.
//   INIT: onFLASH_RESET=0; counter decrements; at 0 drive onFLASH_RESET=1, go IDLE.
//   IDLE: accept when iRQ_REQ && !oRQ_BUSY; next edge: oFLASH_ADDR<=iRQ_ADDR, CE=OE=0,
//         counter<=P_ACC_WAIT-1, go ACCESS.
//   ACCESS: hold pins; decrement; at 0 go LATCH.
//   LATCH: sample iFLASH_DQ into FIFO tail on this edge, go RECOVER.
//   RECOVER: CE=OE=1 for one cycle (tOH/tDF), go IDLE.
//  oRQ_BUSY (comb) = (state!=IDLE) | fifo_full | !ry_s. One read in flight max; acceptance
//   only when FIFO not full guarantees LATCH never overflows.
//  Latency: accept edge E0 -> byte visible (oRD_BUSY=0) at E0+P_ACC_WAIT+1;
//   throughput one byte per P_ACC_WAIT+3 cycles.
//  FIFO: oRD_DATA = head, combinational from storage; pop when iRD_REQ && !oRD_BUSY.
//   Pop on empty ignored. Push+pop same edge: count unchanged, head advances. Pointers wrap
//   modulo P_FIFO_DEPTH; count is P_FIFO_PTR_N+1 bits, full when count==P_FIFO_DEPTH.
//  Pops may occur in any state, including INIT.
//  Address wrap is the requester's responsibility; addresses are used as given.
//  inRESET asserted mid-access: CE/OE return high asynchronously, FIFO flushed, in-flight
//   read discarded, INIT re-run (flash re-reset).
//  ry_s low: no new acceptance; an access already past IDLE completes normally.
// CONFIGURATION
//  NOR_FLASH_PAGE_MODE_EN defined: if a request is accepted in RECOVER-bypass fashion, i.e.
//   LATCH is followed by a pending iRQ_REQ whose address equals last address except bits[2:0],
//   and ry_s=1, FIFO not full, CE/OE stay low, skip RECOVER, load counter P_PAGE_WAIT-1,
//   go ACCESS (accept asserted in LATCH cycle). Any other case: normal RECOVER.
//  Undefined: every access is a full random access with RECOVER; P_PAGE_WAIT unused.
// TESTING
//  Reset release -> onFLASH_RESET low 32 cycles then high; oRQ_BUSY low next cycle if RY=1.
//  Req addr 0x000010, model DQ=0xA5 valid after tACC -> oRD_DATA=0xA5, oRD_BUSY low at E0+8.
//  9 reqs, no pops -> 8 bytes buffered, oRQ_BUSY held; one pop -> 9th read issued, order kept.
//  Pop same edge as LATCH push with 1 entry held -> count stays 1, data order preserved.
//  inRESET low during ACCESS -> CE/OE high immediately, FIFO empty, INIT re-run.
//  PAGE_MODE_EN: addrs 0x100,0x101 back-to-back -> CE/OE stay low, 2nd byte after 3 waits.

Source files
------------

// File: rtl/nor_flash_read_ctrl.sv
// nor_flash_read_ctrl
//   Read-only controller for an x8 asynchronous parallel NOR flash. Accepts
//   byte-address read requests, runs the flash pins with programmable access
//   timing and buffers returned bytes in a show-ahead FIFO for the consumer.
//
// Optional feature macro: NOR_FLASH_PAGE_MODE_EN
//   When defined, a request to the same 8-byte page as the access being
//   latched is accepted in the LATCH cycle. CE/OE stay low, RECOVER is skipped
//   and the shorter P_PAGE_WAIT timing is used. Undefined: every access is a
//   full random access followed by RECOVER.
//
// Ports
//   iCLOCK, inRESET          clock, async active-low reset
//   iRQ_REQ/oRQ_BUSY         request handshake (oRQ_BUSY combinational)
//   iRQ_ADDR                 byte address, sampled on acceptance
//   iRD_REQ/oRD_BUSY         FIFO pop / FIFO empty
//   oRD_DATA                 FIFO head (show-ahead)
//   oFLASH_ADDR, iFLASH_DQ   flash address / data
//   onFLASH_CE/OE/WE         chip, output, write enable (active-low)
//   onFLASH_RESET            flash reset (active-low)
//   onFLASH_WP, onFLASH_BYTE write protect and byte-mode straps
//   inFLASH_RY               flash ready/busy#, asynchronous
module nor_flash_read_ctrl #(
  parameter int unsigned P_ADDR_N     = 23,
  parameter int unsigned P_DATA_N     = 8,
  parameter int unsigned P_FIFO_DEPTH = 8,
  parameter int unsigned P_FIFO_PTR_N = 3,
  parameter int unsigned P_ACC_WAIT   = 7,
  parameter int unsigned P_RST_WAIT   = 32,
  parameter int unsigned P_PAGE_WAIT  = 3
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                iRQ_REQ,
  output logic                oRQ_BUSY,
  input  logic [P_ADDR_N-1:0] iRQ_ADDR,
  input  logic                iRD_REQ,
  output logic                oRD_BUSY,
  output logic [P_DATA_N-1:0] oRD_DATA,
  output logic [P_ADDR_N-1:0] oFLASH_ADDR,
  input  logic [P_DATA_N-1:0] iFLASH_DQ,
  output logic                onFLASH_CE,
  output logic                onFLASH_OE,
  output logic                onFLASH_WE,
  output logic                onFLASH_RESET,
  output logic                onFLASH_WP,
  output logic                onFLASH_BYTE,
  input  logic                inFLASH_RY
);

  localparam int unsigned CNT_MAX0 = (P_RST_WAIT > P_ACC_WAIT) ? P_RST_WAIT : P_ACC_WAIT;
  localparam int unsigned CNT_MAX  = (CNT_MAX0 > P_PAGE_WAIT) ? CNT_MAX0 : P_PAGE_WAIT;
  localparam int unsigned CNT_N    = $clog2(CNT_MAX + 1);
  localparam int unsigned FCNT_N   = P_FIFO_PTR_N + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_ACCESS,
    S_LATCH,
    S_RECOVER
  } state_t;

  state_t                  state_q;
  logic [CNT_N-1:0]        cnt_q;
  logic [P_ADDR_N-1:0]     addr_q;
  logic                    ce_n_q;
  logic                    oe_n_q;
  logic                    rst_n_q;
  logic                    ry_meta_q;
  logic                    ry_s_q;

  logic [P_DATA_N-1:0]     mem_q [P_FIFO_DEPTH];
  logic [P_FIFO_PTR_N-1:0] wr_ptr_q;
  logic [P_FIFO_PTR_N-1:0] rd_ptr_q;
  logic [FCNT_N-1:0]       fcnt_q;
  logic [FCNT_N-1:0]       fcnt_d;

  logic fifo_full_c;
  logic fifo_empty_c;
  logic push_c;
  logic pop_c;
  logic idle_ok_c;
  logic accept_c;

  // Static pin straps: never write, boot block protected, x8 mode.
  assign onFLASH_WE   = 1'b1;
  assign onFLASH_WP   = 1'b0;
  assign onFLASH_BYTE = 1'b0;

  assign oFLASH_ADDR   = addr_q;
  assign onFLASH_CE    = ce_n_q;
  assign onFLASH_OE    = oe_n_q;
  assign onFLASH_RESET = rst_n_q;

  assign fifo_full_c  = (fcnt_q == FCNT_N'(P_FIFO_DEPTH));
  assign fifo_empty_c = (fcnt_q == '0);
  assign push_c       = (state_q == S_LATCH);
  assign pop_c        = iRD_REQ && !fifo_empty_c;

  assign idle_ok_c = (state_q == S_IDLE) && !fifo_full_c && ry_s_q;

`ifdef NOR_FLASH_PAGE_MODE_EN
  logic page_ok_c;
  // Same-page follow-on: the FIFO must have room for this LATCH push plus the next one.
  assign page_ok_c = (state_q == S_LATCH) && iRQ_REQ && ry_s_q &&
                     (iRQ_ADDR[P_ADDR_N-1:3] == addr_q[P_ADDR_N-1:3]) &&
                     (fcnt_q < FCNT_N'(P_FIFO_DEPTH - 1));
  assign oRQ_BUSY  = !(idle_ok_c || page_ok_c);
`else
  assign oRQ_BUSY  = !idle_ok_c;
`endif

  assign accept_c = iRQ_REQ && !oRQ_BUSY;

  assign oRD_BUSY = fifo_empty_c;
  assign oRD_DATA = mem_q[rd_ptr_q];

  // Ready/busy# synchroniser.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      ry_meta_q <= 1'b0;
      ry_s_q    <= 1'b0;
    end else begin
      ry_meta_q <= inFLASH_RY;
      ry_s_q    <= ry_meta_q;
    end
  end

  // Access sequencer and flash pin registers.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_q <= S_INIT;
      cnt_q   <= CNT_N'(P_RST_WAIT);
      addr_q  <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      rst_n_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          // Flash reset pulse spans exactly P_RST_WAIT cycles after release.
          if (cnt_q <= CNT_N'(1)) begin
            cnt_q   <= '0;
            rst_n_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_N'(1);
          end
        end
        S_IDLE: begin
          if (accept_c) begin
            addr_q  <= iRQ_ADDR;
            ce_n_q  <= 1'b0;
            oe_n_q  <= 1'b0;
            cnt_q   <= CNT_N'(P_ACC_WAIT - 1);
            state_q <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= S_LATCH;
          end else begin
            cnt_q <= cnt_q - CNT_N'(1);
          end
        end
        S_LATCH: begin
`ifdef NOR_FLASH_PAGE_MODE_EN
          if (accept_c) begin
            addr_q  <= iRQ_ADDR;
            cnt_q   <= CNT_N'(P_PAGE_WAIT - 1);
            state_q <= S_ACCESS;
          end else begin
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            state_q <= S_RECOVER;
          end
`else
          ce_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          state_q <= S_RECOVER;
`endif
        end
        S_RECOVER: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // FIFO occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    fcnt_d = fcnt_q;
    case ({push_c, pop_c})
      2'b10:   fcnt_d = fcnt_q + FCNT_N'(1);
      2'b01:   fcnt_d = fcnt_q - FCNT_N'(1);
      default: fcnt_d = fcnt_q;
    endcase
  end

  // FIFO storage and pointers; reset flushes contents so the empty head reads 0.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      for (int i = 0; i < int'(P_FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      fcnt_q <= fcnt_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= iFLASH_DQ;
        wr_ptr_q <= (wr_ptr_q == P_FIFO_PTR_N'(P_FIFO_DEPTH - 1)) ? '0
                                                                  : wr_ptr_q + P_FIFO_PTR_N'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= (rd_ptr_q == P_FIFO_PTR_N'(P_FIFO_DEPTH - 1)) ? '0
                                                                  : rd_ptr_q + P_FIFO_PTR_N'(1);
      end
    end
  end

endmodule
